// File: rtl/ram_ctrl.sv
// Command sequencer for an 8-word single-port RAM: single-word write/read
// commands over valid/ready, plus a full-memory scan reporting sum and max.
module ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int SIZE   = 8,
  parameter int ADDR_W = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  input  logic                     i_cmd_we,
  input  logic [ADDR_W-1:0]        i_cmd_addr,
  input  logic [DATA_W-1:0]        i_cmd_data,
  output logic                     o_cmd_ready,
  input  logic                     i_scan_start,
  output logic                     o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_data,
  output logic                     o_scan_done,
  output logic [DATA_W+ADDR_W-1:0] o_scan_sum,
  output logic [DATA_W-1:0]        o_scan_max,
  output logic                     o_ram_write_en,
  output logic [ADDR_W-1:0]        o_ram_addr,
  output logic [DATA_W-1:0]        o_ram_write_data,
  input  logic [DATA_W-1:0]        i_ram_read_data
);

  localparam int SUM_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_RCAP, S_SCAN, S_SDRAIN
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                scan_done_q, scan_done_d;
  logic [SUM_W-1:0]    scan_sum_q, scan_sum_d;
  logic [DATA_W-1:0]   scan_max_q, scan_max_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [SUM_W-1:0]    acc_sum_q, acc_sum_d;
  logic [DATA_W-1:0]   acc_max_q, acc_max_d;
  logic                dvld_q, dvld_d;

  logic [SUM_W-1:0]    sum_nxt;
  logic [DATA_W-1:0]   max_nxt;

  // RAM read data lags the presented address by one edge
  always_comb begin
    sum_nxt = acc_sum_q + SUM_W'(i_ram_read_data);
    max_nxt = (i_ram_read_data > acc_max_q) ? i_ram_read_data : acc_max_q;
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    scan_done_d = 1'b0;
    scan_sum_d  = scan_sum_q;
    scan_max_d  = scan_max_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    acc_sum_d   = acc_sum_q;
    acc_max_d   = acc_max_q;
    dvld_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_scan_start) begin
          state_d    = S_SCAN;
          ram_addr_d = '0;
          acc_sum_d  = '0;
          acc_max_d  = '0;
        end else if (i_cmd_valid && i_cmd_we) begin
          state_d     = S_WRITE;
          ram_we_d    = 1'b1;
          ram_addr_d  = i_cmd_addr;
          ram_wdata_d = i_cmd_data;
        end else if (i_cmd_valid) begin
          state_d    = S_READ;
          ram_addr_d = i_cmd_addr;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ:  state_d = S_RCAP;
      S_RCAP: begin
        rsp_data_d  = i_ram_read_data;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_SCAN: begin
        dvld_d = 1'b1;
        if (dvld_q) begin
          acc_sum_d = sum_nxt;
          acc_max_d = max_nxt;
        end
        if (ram_addr_q == LAST_ADDR) state_d = S_SDRAIN;
        else ram_addr_d = ram_addr_q + 1'b1;
      end
      S_SDRAIN: begin
        scan_sum_d  = sum_nxt;
        scan_max_d  = max_nxt;
        scan_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      scan_done_q <= 1'b0;
      scan_sum_q  <= '0;
      scan_max_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      dvld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      scan_done_q <= scan_done_d;
      scan_sum_q  <= scan_sum_d;
      scan_max_q  <= scan_max_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      acc_sum_q   <= acc_sum_d;
      acc_max_q   <= acc_max_d;
      dvld_q      <= dvld_d;
    end
  end

  assign o_cmd_ready      = cmd_ready_q;
  assign o_rsp_valid      = rsp_valid_q;
  assign o_rsp_data       = rsp_data_q;
  assign o_scan_done      = scan_done_q;
  assign o_scan_sum       = scan_sum_q;
  assign o_scan_max       = scan_max_q;
  assign o_ram_write_en   = ram_we_q;
  assign o_ram_addr       = ram_addr_q;
  assign o_ram_write_data = ram_wdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural 8-word RAM, a table of write/read/scan
// operations, and hand sequences for scan priority, mid-scan reset, back-to-back.
module tb_ram_ctrl;
  localparam int DATA_W = 8;
  localparam int SIZE   = 8;
  localparam int ADDR_W = 3;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_cmd_valid = 1'b0, i_cmd_we = 1'b0, i_scan_start = 1'b0;
  logic [ADDR_W-1:0] i_cmd_addr = '0;
  logic [DATA_W-1:0] i_cmd_data = '0;
  logic              o_cmd_ready, o_rsp_valid, o_scan_done, o_ram_write_en;
  logic [DATA_W-1:0] o_rsp_data, o_scan_max, o_ram_write_data, ram_rd;
  logic [DATA_W+ADDR_W-1:0] o_scan_sum;
  logic [ADDR_W-1:0] o_ram_addr;

  int errors = 0;
  int checks = 0;

  ram_ctrl #(.DATA_W(DATA_W), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr),
    .i_cmd_data(i_cmd_data), .o_cmd_ready(o_cmd_ready), .i_scan_start(i_scan_start),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_scan_done(o_scan_done),
    .o_scan_sum(o_scan_sum), .o_scan_max(o_scan_max),
    .o_ram_write_en(o_ram_write_en), .o_ram_addr(o_ram_addr),
    .o_ram_write_data(o_ram_write_data), .i_ram_read_data(ram_rd)
  );

  always #5 i_clk = ~i_clk;

  // single-port RAM: registered read that updates only while write enable is low
  logic [DATA_W-1:0] mem [SIZE];
  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
      ram_rd <= '0;
    end else if (o_ram_write_en) mem[o_ram_addr] <= o_ram_write_data;
    else ram_rd <= mem[o_ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // all tasks start and end just after a negedge with the DUT idle
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    i_cmd_valid = 1'b1; i_cmd_we = 1'b1; i_cmd_addr = a; i_cmd_data = d;
    @(posedge i_clk); @(negedge i_clk);
    i_cmd_valid = 1'b0;
    chk("wr_ready_low", o_cmd_ready, 0);
    chk("wr_we_high", o_ram_write_en, 1);
    chk("wr_addr", o_ram_addr, a);
    chk("wr_data", o_ram_write_data, d);
    @(negedge i_clk);
    chk("wr_ready_back", o_cmd_ready, 1);
    chk("wr_we_low", o_ram_write_en, 0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = a;
    @(posedge i_clk); @(negedge i_clk);
    i_cmd_valid = 1'b0;
    chk("rd_ready_low0", o_cmd_ready, 0);
    chk("rd_addr", o_ram_addr, a);
    chk("rd_we_low", o_ram_write_en, 0);
    chk("rd_no_rsp0", o_rsp_valid, 0);
    @(negedge i_clk);
    chk("rd_ready_low1", o_cmd_ready, 0);
    chk("rd_no_rsp1", o_rsp_valid, 0);
    @(negedge i_clk);
    chk("rd_rsp_valid", o_rsp_valid, 1);
    chk("rd_rsp_data", o_rsp_data, exp);
    chk("rd_ready_back", o_cmd_ready, 1);
    @(negedge i_clk);
    chk("rd_rsp_pulse", o_rsp_valid, 0);
    chk("rd_rsp_hold", o_rsp_data, exp);
  endtask

  task automatic do_scan(input logic [DATA_W+ADDR_W-1:0] es, input logic [DATA_W-1:0] em);
    int done_at, dn, rn;
    done_at = -1; dn = 0; rn = 0;
    i_scan_start = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_scan_start = 1'b0;
    chk("scan_ready_low", o_cmd_ready, 0);
    for (int n = 0; n < 14; n++) begin
      if (n > 0) @(negedge i_clk);
      if (o_scan_done) begin
        dn++;
        if (done_at < 0) done_at = n;
        chk("scan_sum", o_scan_sum, es);
        chk("scan_max", o_scan_max, em);
        chk("scan_done_ready", o_cmd_ready, 1);
      end
      if (o_rsp_valid) rn++;
    end
    chk("scan_latency", done_at, 9);
    chk("scan_done_count", dn, 1);
    chk("scan_no_rsp", rn, 0);
    chk("scan_sum_hold", o_scan_sum, es);
  endtask

  localparam int K_WR = 0, K_RD = 1, K_SC = 2;
  typedef struct {
    int                       kind;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        data;  // write data or expected read data
    logic [DATA_W+ADDR_W-1:0] esum;
    logic [DATA_W-1:0]        emax;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl.push_back('{K_RD, 3'd3, 8'h00, 0, 0});
    tbl.push_back('{K_WR, 3'd3, 8'hA5, 0, 0});
    tbl.push_back('{K_RD, 3'd3, 8'hA5, 0, 0});
    for (int i = 0; i < SIZE; i++) tbl.push_back('{K_WR, ADDR_W'(i), DATA_W'(i + 1), 0, 0});
    tbl.push_back('{K_SC, 3'd0, 8'h00, 11'd36, 8'd8});
    tbl.push_back('{K_SC, 3'd0, 8'h00, 11'd36, 8'd8});
    tbl.push_back('{K_RD, 3'd5, 8'h06, 0, 0});
    for (int i = 0; i < SIZE; i++) tbl.push_back('{K_WR, ADDR_W'(i), 8'hFF, 0, 0});
    tbl.push_back('{K_SC, 3'd0, 8'h00, 11'h7F8, 8'hFF});
    tbl.push_back('{K_RD, 3'd7, 8'hFF, 0, 0});

    // reset state
    @(negedge i_clk); @(negedge i_clk);
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_done", o_scan_done, 0);
    chk("rst_sum", o_scan_sum, 0);
    chk("rst_max", o_scan_max, 0);
    chk("rst_we", o_ram_write_en, 0);
    chk("rst_addr", o_ram_addr, 0);
    chk("rst_rsp_data", o_rsp_data, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_WR: do_write(tbl[i].addr, tbl[i].data);
        K_RD: do_read(tbl[i].addr, tbl[i].data);
        default: do_scan(tbl[i].esum, tbl[i].emax);
      endcase
    end

    // scan wins over a held read; the read then runs against unchanged memory
    begin
      int dn, rn, dcyc, rcyc, both;
      logic [DATA_W-1:0] rdat;
      dn = 0; rn = 0; dcyc = -10; rcyc = -1; both = 0; rdat = '0;
      do_write(3'd5, 8'h5A);
      i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = 3'd5; i_scan_start = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
      i_scan_start = 1'b0;
      chk("prio_in_scan", o_ram_write_en | o_cmd_ready, 0);
      for (int n = 0; n < 18; n++) begin
        if (n > 0) @(negedge i_clk);
        if (n == dcyc + 1) i_cmd_valid = 1'b0;
        if (o_scan_done) begin
          dn++; dcyc = n;
          chk("prio_sum", o_scan_sum, 11'd1875);
          chk("prio_max", o_scan_max, 8'hFF);
        end
        if (o_rsp_valid) begin rn++; rcyc = n; rdat = o_rsp_data; end
        if (o_rsp_valid && o_scan_done) both++;
      end
      i_cmd_valid = 1'b0;
      chk("prio_done_cyc", dcyc, 9);
      chk("prio_done_cnt", dn, 1);
      chk("prio_rsp_cnt", rn, 1);
      chk("prio_rsp_cyc", rcyc, 12);
      chk("prio_rsp_data", rdat, 8'h5A);
      chk("prio_no_overlap", both, 0);
    end

    // reset during scan cycle 4 aborts with everything cleared
    begin
      int dn;
      dn = 0;
      i_scan_start = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
      i_scan_start = 1'b0;
      repeat (4) @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      chk("arst_ready", o_cmd_ready, 1);
      chk("arst_sum", o_scan_sum, 0);
      chk("arst_max", o_scan_max, 0);
      chk("arst_rsp_data", o_rsp_data, 0);
      chk("arst_addr", o_ram_addr, 0);
      chk("arst_done", o_scan_done, 0);
      @(posedge i_clk); @(posedge i_clk); @(negedge i_clk);
      i_rst = 1'b0;
      for (int n = 0; n < 12; n++) begin
        @(negedge i_clk);
        if (o_scan_done || o_rsp_valid) dn++;
      end
      chk("arst_no_pulse", dn, 0);
      do_read(3'd0, 8'h00);
      do_read(3'd5, 8'h00);
    end

    // back-to-back write then read, response held across the next write
    do_write(3'd2, 8'h3C);
    do_read(3'd2, 8'h3C);
    do_write(3'd6, 8'h11);
    chk("b2b_rsp_hold", o_rsp_data, 8'h3C);
    do_read(3'd6, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Command sequencer that sits directly upstream of the 8-word single-port RAM and owns its `i_write_en`/`i_addr`/`i_write_data` pins. It accepts single-word write and read commands over a valid/ready handshake and returns read data with a response strobe. It also runs a full-memory scan that reads every word back-to-back and reports the sum and maximum. The RAM's `o_read_data` is registered with one-cycle latency and updates only when its write enable is low; this block's timing is built around that.

## Interface
- `DATA_W`, default 8: RAM word width.
- `SIZE`, default 8: number of RAM words; must equal 2**ADDR_W.
- `ADDR_W`, default 3: RAM address width.
- `i_clk`  in  1  single clock, rising-edge; same net as the RAM clock.
- `i_rst`  in  1  reset, asynchronous, active-high; also drives the RAM's `i_rst`.
- `i_cmd_valid`  in  1  command present; held stable until accepted.
- `i_cmd_we`  in  1  1 = write, 0 = read.
- `i_cmd_addr`  in  ADDR_W  command address.
- `i_cmd_data`  in  DATA_W  write data (ignored for reads).
- `o_cmd_ready`  out  1  high only in IDLE; a command is accepted on an edge where `i_cmd_valid & o_cmd_ready` is true and `i_scan_start` is low.
- `i_scan_start`  in  1  scan request, sampled only in IDLE.
- `o_rsp_valid`  out  1  one-cycle pulse; `o_rsp_data` is valid.
- `o_rsp_data`  out  DATA_W  read result; holds its value until the next read response.
- `o_scan_done`  out  1  one-cycle pulse at the end of a scan.
- `o_scan_sum`  out  DATA_W+ADDR_W  sum of all words; holds until the next scan completes.
- `o_scan_max`  out  DATA_W  unsigned maximum word; holds until the next scan completes.
- `o_ram_write_en`  out  1  to RAM `i_write_en`.
- `o_ram_addr`  out  ADDR_W  to RAM `i_addr`.
- `o_ram_write_data`  out  DATA_W  to RAM `i_write_data`.
- `i_ram_read_data`  in  DATA_W  from RAM `o_read_data`.

## Operation
- All outputs are registered.
- States:
  - IDLE: ready = 1, `o_ram_write_en` = 0.
  - WRITE
  - READ
  - RCAP
  - SCAN
  - SDRAIN
- IDLE:
  - `i_scan_start` = 1 → SCAN with `o_ram_addr` = 0. Scan has priority over a pending command; that command is not accepted and stays pending.
  - Else an accepted write → WRITE with `o_ram_write_en` = 1 and addr/data latched.
  - Else an accepted read → READ with `o_ram_write_en` = 0 and addr latched.
- WRITE: lasts one cycle; the RAM stores on the exiting edge; → IDLE with `o_ram_write_en` cleared.
- READ: lasts one cycle; the RAM captures `mem[addr]` on the exiting edge; → RCAP.
- RCAP: registers `i_ram_read_data` into `o_rsp_data` and sets `o_rsp_valid` = 1 for one cycle; → IDLE.
- SCAN: `o_ram_addr` increments by 1 each edge.
  - A one-cycle-delayed "data valid" flag qualifies accumulation.
  - On each qualified edge: sum += `i_ram_read_data` and max = max(max, `i_ram_read_data`).
  - Accumulators clear to 0 on scan entry.
  - When `o_ram_addr` == SIZE-1, the next edge → SDRAIN.
- SDRAIN: accumulates the last word, loads `o_scan_sum`/`o_scan_max`, pulses `o_scan_done`; → IDLE.
- Sum width DATA_W+ADDR_W never overflows; the worst case is 8 × 255 = 2040.
- Max comparison is unsigned.
- Scan does not modify memory.
- Addresses wrap nowhere: the scan stops at SIZE-1.
- During reset the RAM synchronously clears; the first command after reset reads 0 from every address.

## Timing
- Edge E0 is the accept edge.
- Write: WRITE during E0–E1, RAM updated at E1, ready high after E1. Throughput is one write per 2 cycles.
- Read: RAM samples at E1; `o_rsp_valid` is high between E2 and E3; ready high after E2. A read immediately after a write to the same address returns the new data.
- Scan:
  - Address k is presented after E(k).
  - Data is accumulated at E(k+2).
  - `o_scan_done` is high between E(SIZE+1) and E(SIZE+2), i.e. E9–E10 for SIZE = 8.
  - Ready high after E(SIZE+1).
- `o_rsp_valid` and `o_scan_done` are never high in the same cycle.
- Reset value of every output is 0, except `o_cmd_ready` = 1; state = IDLE.
- Reset asserted mid-operation aborts immediately:
  - no `o_rsp_valid` or `o_scan_done` pulse;
  - `o_scan_sum`/`o_scan_max`/`o_rsp_data` return to 0;
  - a pending RAM write may or may not have completed and must not be relied upon.

## Test plan
- Write 0xA5 to addr 3, then read addr 3 → `o_rsp_valid` pulses exactly 2 edges after the read accept, with `o_rsp_data` = 0xA5; ready is low for 1 cycle (write) and 2 cycles (read).
- Write values 1..8 to addrs 0..7, then scan → `o_scan_done` 9 edges after start, with sum = 36 and max = 8; a second scan gives identical results.
- Write 0xFF to all words, then scan → sum = 2040 (0x7F8) and max = 0xFF; no overflow.
- Hold `i_cmd_valid` (read addr 5) and pulse `i_scan_start` on the same IDLE edge → scan runs first; the read is then accepted and returns mem[5]; exactly one done pulse and one rsp pulse occur.
- Assert `i_rst` at scan cycle 4 → all outputs 0 and ready = 1 asynchronously; no done pulse; a subsequent read of any address returns 0.
- Back-to-back: read of an address after reset → 0; write 0x3C, immediately read → 0x3C; `o_rsp_data` holds 0x3C through the following write.
